// File: rtl/hidden_ram_writer_if.sv
// Pixel stream in, RAM write port out, for the hidden_ram line-buffer writer.
// Latency/backpressure are defined by the module using the slave modport.
interface hidden_ram_writer_if #(
    parameter int AW = 4
);
    logic [15:0]   i_pix;
    logic          i_pix_valid;
    logic          o_pix_ready;
    logic [127:0]  o_wdata;
    logic [AW-1:0] o_addr_w;
    logic          o_write;

    modport master (
        output i_pix, i_pix_valid,
        input  o_pix_ready, o_wdata, o_addr_w, o_write
    );

    modport slave (
        input  i_pix, i_pix_valid,
        output o_pix_ready, o_wdata, o_addr_w, o_write
    );
endinterface

// File: rtl/hidden_ram_writer.sv
// Packs eight 16-bit pixels per 128-bit hidden_ram word and tracks unread occupancy.
// Latency: write strobe one cycle after the 8th pixel; 8 pixels per 9 cycles max.
// Backpressure: ready drops during the write cycle, when all entries are occupied, or on flush.
module hidden_ram_writer #(
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic                i_clk,
    input  logic                i_reset_p,
    hidden_ram_writer_if.slave  bus,
    input  logic                i_flush,
    input  logic                i_word_consumed,
    output logic [AW:0]         o_level,
    output logic                o_empty,
    output logic                o_full,
    output logic                o_err_underflow
);
    typedef enum logic {S_FILL, S_WRITE} state_t;

    localparam logic [AW:0]   DEPTH_L = (AW+1)'(DEPTH);
    localparam logic [AW:0]   ONE_L   = (AW+1)'(1);
    localparam logic [AW-1:0] ONE_A   = AW'(1);

    state_t        state_q;
    logic [2:0]    k_q;
    logic [127:0]  wdata_q;
    logic [AW-1:0] addr_q;
    logic [AW:0]   level_q, level_d;
    logic          err_q;

    logic accept, write, consume_ok, underflow;

    always_comb begin
        bus.o_pix_ready = (state_q == S_FILL) && (level_q < DEPTH_L) && !i_flush;
        accept          = bus.i_pix_valid && bus.o_pix_ready;
        write           = (state_q == S_WRITE) && !i_flush;
        consume_ok      = i_word_consumed && (level_q != '0) && !i_flush;
        underflow       = i_word_consumed && (level_q == '0) && !i_flush;
    end

    // Write and consume in the same cycle cancel out.
    always_comb begin
        level_d = level_q;
        if (i_flush) begin
            level_d = '0;
        end else if (write && !consume_ok) begin
            level_d = level_q + ONE_L;
        end else if (consume_ok && !write) begin
            level_d = level_q - ONE_L;
        end
    end

    always_ff @(posedge i_clk or posedge i_reset_p) begin
        if (i_reset_p) begin
            state_q <= S_FILL;
            k_q     <= '0;
            wdata_q <= '0;
            addr_q  <= '0;
            level_q <= '0;
            err_q   <= 1'b0;
        end else begin
            level_q <= level_d;
            if (i_flush) begin
                state_q <= S_FILL;
                k_q     <= '0;
                addr_q  <= '0;
                err_q   <= 1'b0;
            end else begin
                if (underflow) begin
                    err_q <= 1'b1;
                end
                case (state_q)
                    S_FILL: begin
                        if (accept) begin
                            wdata_q[16*k_q +: 16] <= bus.i_pix;
                            k_q                   <= k_q + 3'd1;
                            if (k_q == 3'd7) begin
                                state_q <= S_WRITE;
                            end
                        end
                    end
                    S_WRITE: begin
                        addr_q  <= addr_q + ONE_A;
                        state_q <= S_FILL;
                    end
                    default: state_q <= S_FILL;
                endcase
            end
        end
    end

    assign bus.o_wdata     = wdata_q;
    assign bus.o_addr_w    = addr_q;
    assign bus.o_write     = write;
    assign o_level         = level_q;
    assign o_empty         = (level_q == '0);
    assign o_full          = (level_q == DEPTH_L);
    assign o_err_underflow = err_q;
endmodule

// File: tb/tb_hidden_ram_writer.sv
// Directed and randomized checks of hidden_ram_writer against a pixel-queue/level model.
module tb_hidden_ram_writer;
    localparam int DEPTH = 16;
    localparam int AW    = 4;

    logic          i_clk = 1'b0;
    logic          i_reset_p;
    logic          i_flush;
    logic          i_word_consumed;
    logic [AW:0]   o_level;
    logic          o_empty, o_full, o_err_underflow;

    hidden_ram_writer_if #(.AW(AW)) bus ();

    hidden_ram_writer #(.DEPTH(DEPTH), .AW(AW)) dut (
        .i_clk           (i_clk),
        .i_reset_p       (i_reset_p),
        .bus             (bus),
        .i_flush         (i_flush),
        .i_word_consumed (i_word_consumed),
        .o_level         (o_level),
        .o_empty         (o_empty),
        .o_full          (o_full),
        .o_err_underflow (o_err_underflow)
    );

    always #5 i_clk = ~i_clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: pixels collected so far, a finished word waiting to be written,
    // number of unread words, and the next RAM address.
    logic [15:0]  m_part[8];
    int           m_cnt;
    bit           m_pend;
    logic [127:0] m_word;
    int           m_level;
    int           m_ptr;
    bit           m_err;

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_cnt = 0; m_pend = 0; m_word = '0; m_level = 0; m_ptr = 0; m_err = 0;
    endtask

    // One clock cycle: drive inputs just after a falling edge, check, advance model at the rising edge.
    task automatic step(input bit v, input logic [15:0] p, input bit c, input bit f, output bit acc);
        bit exp_rdy, exp_wr;
        int old_level;
        bus.i_pix_valid = v;
        bus.i_pix       = p;
        i_word_consumed = c;
        i_flush         = f;
        #1;
        exp_rdy = !m_pend && (m_level < DEPTH) && !f;
        exp_wr  = m_pend && !f;
        check_eq("ready", 128'(bus.o_pix_ready), 128'(exp_rdy));
        check_eq("write", 128'(bus.o_write), 128'(exp_wr));
        if (exp_wr) begin
            check_eq("wdata", bus.o_wdata, m_word);
            check_eq("addr", 128'(bus.o_addr_w), 128'(m_ptr));
        end
        check_eq("level", 128'(o_level), 128'(m_level));
        check_eq("empty", 128'(o_empty), 128'(m_level == 0));
        check_eq("full", 128'(o_full), 128'(m_level == DEPTH));
        check_eq("err", 128'(o_err_underflow), 128'(m_err));
        acc = v && exp_rdy;
        @(posedge i_clk);
        old_level = m_level;
        if (f) begin
            model_reset();
        end else begin
            if (exp_wr) begin
                m_ptr   = (m_ptr + 1) % DEPTH;
                m_pend  = 0;
                m_level = m_level + 1;
            end
            if (c) begin
                if (old_level > 0) m_level = m_level - 1;
                else               m_err = 1;
            end
            if (acc) begin
                m_part[m_cnt] = p;
                m_cnt++;
                if (m_cnt == 8) begin
                    for (int i = 0; i < 8; i++) m_word[16*i +: 16] = m_part[i];
                    m_cnt  = 0;
                    m_pend = 1;
                end
            end
        end
        @(negedge i_clk);
    endtask

    task automatic idle();
        bit a;
        step(0, 16'h0, 0, 0, a);
    endtask

    // Sends n pixels with values start, start+1, ...; bounded wait on acceptance.
    task automatic send_pixels(input int n, input logic [15:0] start);
        bit a;
        int got = 0;
        int guard = 0;
        while (got < n && guard < n * 4 + 20) begin
            step(1, start + 16'(got), 0, 0, a);
            if (a) got++;
            guard++;
        end
        check_eq("send_timeout", 128'(got), 128'(n));
    endtask

    initial begin
        bit a;
        logic [127:0] exp1;
        exp1 = 128'h0008_0007_0006_0005_0004_0003_0002_0001;
        i_reset_p = 1'b1;
        i_flush = 0; i_word_consumed = 0;
        bus.i_pix_valid = 0; bus.i_pix = '0;
        model_reset();
        @(negedge i_clk);
        check_eq("rst_wdata", bus.o_wdata, '0);
        check_eq("rst_addr", 128'(bus.o_addr_w), 0);
        check_eq("rst_level", 128'(o_level), 0);
        check_eq("rst_write", 128'(bus.o_write), 0);
        check_eq("rst_empty", 128'(o_empty), 1);
        check_eq("rst_full", 128'(o_full), 0);
        check_eq("rst_err", 128'(o_err_underflow), 0);
        check_eq("rst_ready", 128'(bus.o_pix_ready), 1);
        @(negedge i_clk);
        i_reset_p = 1'b0;

        // Single word.
        send_pixels(8, 16'h0001);
        check_eq("t1_write", 128'(bus.o_write), 1);
        check_eq("t1_wdata", bus.o_wdata, exp1);
        check_eq("t1_addr", 128'(bus.o_addr_w), 0);
        check_eq("t1_ready_low", 128'(bus.o_pix_ready), 0);
        idle();
        check_eq("t1_level", 128'(o_level), 1);

        // Fill to full, then hold a pixel valid against back-pressure.
        send_pixels(120, 16'h1000);
        idle();
        check_eq("t2_full", 128'(o_full), 1);
        check_eq("t2_level", 128'(o_level), 16);
        for (int i = 0; i < 5; i++) begin
            step(1, 16'hDEAD, 0, 0, a);
            check_eq("t2_not_taken", 128'(a), 0);
        end

        // Wrap-around after one consume.
        step(0, 16'h0, 1, 0, a);
        check_eq("t3_level", 128'(o_level), 15);
        check_eq("t3_ready", 128'(bus.o_pix_ready), 1);
        send_pixels(8, 16'h2000);
        check_eq("t3_addr", 128'(bus.o_addr_w), 0);
        idle();
        check_eq("t3_level_full", 128'(o_level), 16);

        // Consume coinciding with a write; consume while empty.
        step(0, 16'h0, 0, 1, a);
        send_pixels(40, 16'h3000);
        idle();
        check_eq("t4_level5", 128'(o_level), 5);
        send_pixels(8, 16'h3100);
        step(0, 16'h0, 1, 0, a);
        check_eq("t4_level_same", 128'(o_level), 5);
        step(0, 16'h0, 0, 1, a);
        step(0, 16'h0, 1, 0, a);
        check_eq("t4_underflow", 128'(o_err_underflow), 1);
        check_eq("t4_level0", 128'(o_level), 0);
        idle();
        check_eq("t4_sticky", 128'(o_err_underflow), 1);
        step(0, 16'h0, 0, 1, a);
        check_eq("t4_err_clr", 128'(o_err_underflow), 0);

        // Flush mid-word and during the write cycle.
        send_pixels(3, 16'h4000);
        step(1, 16'hBEEF, 0, 1, a);
        check_eq("t5_flush_acc", 128'(a), 0);
        send_pixels(8, 16'h0100);
        check_eq("t5_write", 128'(bus.o_write), 1);
        check_eq("t5_addr", 128'(bus.o_addr_w), 0);
        check_eq("t5_lsb", 128'(bus.o_wdata[15:0]), 128'h0100);
        idle();
        send_pixels(8, 16'h5000);
        step(0, 16'h0, 0, 1, a);
        check_eq("t5_level", 128'(o_level), 0);

        // Asynchronous reset mid-word and mid-cycle.
        send_pixels(3, 16'h0A01);
        bus.i_pix_valid = 1;
        #2;
        i_reset_p = 1'b1;
        #1;
        check_eq("t6_wdata", bus.o_wdata, '0);
        check_eq("t6_addr", 128'(bus.o_addr_w), 0);
        check_eq("t6_level", 128'(o_level), 0);
        check_eq("t6_write", 128'(bus.o_write), 0);
        check_eq("t6_empty", 128'(o_empty), 1);
        check_eq("t6_err", 128'(o_err_underflow), 0);
        check_eq("t6_ready", 128'(bus.o_pix_ready), 1);
        @(negedge i_clk);
        i_reset_p = 1'b0;
        model_reset();
        send_pixels(8, 16'h0C00);
        check_eq("t6_addr_after", 128'(bus.o_addr_w), 0);
        check_eq("t6_lsb_after", 128'(bus.o_wdata[15:0]), 128'h0C00);
        idle();

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            step($urandom_range(0, 9) < 7, 16'($urandom), $urandom_range(0, 9) < 2,
                 $urandom_range(0, 99) == 0, a);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
